// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage pipelined carry-lookahead adder/subtractor.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with in_a, in_b,
//   in_cin, in_sub; out_valid/out_ready with out_sum, out_cout, out_ovf.
module cla_pipe_adder #(
  parameter int NBIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NBIT-1:0] in_a,
  input  logic [NBIT-1:0] in_b,
  input  logic            in_cin,
  input  logic            in_sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NBIT-1:0] out_sum,
  output logic            out_cout,
  output logic            out_ovf
);
  localparam int NNL = NBIT * (NBIT + 3) / 2;

  // operand preparation
  logic [NBIT-1:0] bb;
  logic [NBIT-1:0] g;
  logic [NBIT-1:0] p;
  logic            c0;
  logic [NNL-1:0]  n;

  assign bb = in_sub ? ~in_b : in_b;
  assign c0 = in_sub | in_cin;
  assign g  = in_a & bb;
  assign p  = in_a ^ bb;

  // Product terms of carry c_i start at offset base(i) = sum_{k<i}(k+1).
  // Order per carry: g[0]-term .. g[i-1]-term, then the c0 term.
  for (genvar i = 1; i <= NBIT; i++) begin : g_car
    localparam int B = (i - 1) * i / 2 + (i - 1);
    for (genvar j = 0; j < i; j++) begin : g_term
      if (j == i - 1) begin : g_last
        assign n[B+j] = g[j];
      end else begin : g_run
        assign n[B+j] = g[j] & (&p[i-1:j+1]);
      end
    end
    assign n[B+i] = c0 & (&p[i-1:0]);
  end

  // handshake
  logic v1;
  logic adv1;
  logic adv2;

  assign adv2     = !out_valid | out_ready;
  assign adv1     = !v1 | adv2;
  assign in_ready = !rst & adv1;

  // stage 1
  logic [NBIT-1:0] p_q;
  logic            c0_q;
  logic [NNL-1:0]  n_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid;
    end
  end

  // Payload needs no reset: it is only consumed when v1 is set.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      p_q  <= p;
      c0_q <= c0;
      n_q  <= n;
    end
  end

  // stage 2: carries are the XOR (equivalently OR) of disjoint terms
  logic [NBIT:0] c;

  assign c[0] = c0_q;

  for (genvar i = 1; i <= NBIT; i++) begin : g_xor
    localparam int B = (i - 1) * i / 2 + (i - 1);
    assign c[i] = ^n_q[B+i:B];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (adv2) begin
      out_valid <= v1;
      if (v1) begin
        out_sum  <= p_q ^ c[NBIT-1:0];
        out_cout <= c[NBIT];
        out_ovf  <= c[NBIT] ^ c[NBIT-1];
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed table, backpressure, reset and random
//   sweep over NBIT=4/8/16 instances sharing one handshake stream.
module tb_cla_pipe_adder;

  typedef struct {
    longint sum;
    bit     cout;
    bit     ovf;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;

  logic        ir4, ir8, ir16;
  logic        ov4, ov8, ov16;
  logic [3:0]  sum4;
  logic [7:0]  sum8;
  logic [15:0] sum16;
  logic        co4, co8, co16;
  logic        of4, of8, of16;

  int total = 0;
  int bad   = 0;
  int nacc  = 0;
  int nout  = 0;
  int nblk  = 0;

  exp_t q4[$];
  exp_t q8[$];
  exp_t q16[$];

  bit          hold = 1'b0;
  logic [63:0] h8;
  logic [63:0] h16;

  always #5 clk = ~clk;

  cla_pipe_adder #(.NBIT(4)) u4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir4),
    .in_a(a[3:0]), .in_b(b[3:0]),
    .in_cin(cin), .in_sub(sub),
    .out_valid(ov4), .out_ready(out_ready),
    .out_sum(sum4), .out_cout(co4), .out_ovf(of4)
  );

  cla_pipe_adder #(.NBIT(8)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir8),
    .in_a(a[7:0]), .in_b(b[7:0]),
    .in_cin(cin), .in_sub(sub),
    .out_valid(ov8), .out_ready(out_ready),
    .out_sum(sum8), .out_cout(co8), .out_ovf(of8)
  );

  cla_pipe_adder #(.NBIT(16)) u16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir16),
    .in_a(a[15:0]), .in_b(b[15:0]),
    .in_cin(cin), .in_sub(sub),
    .out_valid(ov16), .out_ready(out_ready),
    .out_sum(sum16), .out_cout(co16), .out_ovf(of16)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  // Behavioural reference: plain integer arithmetic, signed range test.
  function automatic exp_t model(input int w, input logic [31:0] x,
                                 input logic [31:0] y, input logic ci,
                                 input logic sb);
    exp_t   e;
    longint m, hi, ux, uy, sx, sy, ru, rs;
    m  = (longint'(1) << w) - 1;
    hi = longint'(1) << (w - 1);
    ux = longint'(x) & m;
    uy = longint'(y) & m;
    sx = (ux >= hi) ? ux - 2 * hi : ux;
    sy = (uy >= hi) ? uy - 2 * hi : uy;
    if (sb) begin
      ru = ux + (2 * hi - uy);
      rs = sx - sy;
    end else begin
      ru = ux + uy + longint'(ci);
      rs = sx + sy + longint'(ci);
    end
    e.sum  = ru & m;
    e.cout = ((ru >> w) & 1) != 0;
    e.ovf  = (rs >= hi) || (rs < -hi);
    return e;
  endfunction

  task automatic chk_out(input string nm, input int have, input exp_t e,
                         input logic [31:0] s, input logic c,
                         input logic o);
    if (have == 0) chk({nm, "_ghost"}, 64'd1, 64'd0);
    else chk(nm, {s, c, o}, {e.sum[31:0], e.cout, e.ovf});
  endtask

  // One cycle: entered just after a negedge with inputs driven.
  task automatic step();
    int   occ;
    int   have;
    exp_t e;
    #1;
    if (hold) begin
      chk("hold8", {ov8, co8, of8, sum8}, h8);
      chk("hold16", {ov16, co16, of16, sum16}, h16);
    end
    hold = ov8 && !out_ready;
    h8   = {ov8, co8, of8, sum8};
    h16  = {ov16, co16, of16, sum16};
    occ = q8.size();
    chk("in_ready", ir8, !rst && (occ < 2 || out_ready));
    if (out_ready && ov4) begin
      have = q4.size();
      if (have != 0) e = q4.pop_front();
      chk_out("out4", have, e, sum4, co4, of4);
    end
    if (out_ready && ov8) begin
      have = q8.size();
      nout++;
      if (have != 0) e = q8.pop_front();
      chk_out("out8", have, e, sum8, co8, of8);
    end
    if (out_ready && ov16) begin
      have = q16.size();
      if (have != 0) e = q16.pop_front();
      chk_out("out16", have, e, sum16, co16, of16);
    end
    if (in_valid && ir8) begin
      nacc++;
      q4.push_back(model(4, a, b, cin, sub));
      q8.push_back(model(8, a, b, cin, sub));
      q16.push_back(model(16, a, b, cin, sub));
    end
    if (in_valid && !ir8) nblk++;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[8];
    int   base;
    int   nb;

    tv[0] = '{8'h3C, 8'h05, 1'b1, 1'b0, 8'h42, 1'b0, 1'b0};
    tv[1] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tv[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tv[3] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
    tv[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    tv[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tv[6] = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tv[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a   = '0;
    b   = '0;
    cin = 1'b0;
    sub = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", ov8, 1'b0);
    chk("rst_sum", {co8, of8, sum8}, 64'd0);
    chk("rst_ready", ir8, 1'b0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", ir8, 1'b1);
    @(negedge clk);

    // directed table with latency check
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      a   = {24'd0, tv[i].a};
      b   = {24'd0, tv[i].b};
      cin = tv[i].cin;
      sub = tv[i].sub;
      #1;
      chk($sformatf("v%0d_accept", i), ir8, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_lat1", i), ov8, 1'b0);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_lat2", i), ov8, 1'b1);
      chk($sformatf("v%0d_res", i), {sum8, co8, of8},
          {tv[i].sum, tv[i].cout, tv[i].ovf});
      @(negedge clk);
    end
    #1;
    chk("table_drained", ov8, 1'b0);
    @(negedge clk);

    // backpressure: 5 beats, out_ready low for cycles 3..6
    base = nout;
    nb   = nacc;
    nblk = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (nacc - nb) < 5;
      a   = $urandom;
      b   = $urandom;
      cin = 1'(($urandom % 2));
      sub = 1'(($urandom % 2));
      step();
    end
    chk("bp_count", nout - base, 5);
    chk("bp_blocked", nblk > 0, 1'b1);
    chk("bp_empty", q8.size(), 0);

    // reset with two beats in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a = $urandom;
      b = $urandom;
      step();
    end
    chk("rf_inflight", q8.size(), 2);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rf_ready_low", ir8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rf_valid", {ov4, ov8, ov16}, 64'd0);
    chk("rf_out8", {co8, of8, sum8}, 64'd0);
    chk("rf_out16", {co16, of16, sum16}, 64'd0);
    chk("rf_ready", ir8, 1'b1);
    q4.delete();
    q8.delete();
    q16.delete();
    hold = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (4) step();

    // random sweep with random stalls
    nb = nacc;
    for (int c = 0; c < 40000 && (nacc - nb) < 10000; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      a   = $urandom;
      b   = $urandom;
      cin = 1'(($urandom % 2));
      sub = 1'(($urandom % 2));
      step();
    end
    chk("rand_beats", (nacc - nb) >= 10000, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    chk("drain4", q4.size(), 0);
    chk("drain8", q8.size(), 0);
    chk("drain16", q16.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
